// File: rtl/lane_scheduler.sv
// lane_scheduler
//   Four-lane slot scheduler. Each lane owns a one-word hold register and
//   a full flag. Every clock edge in RUN or FLUSH issues one output slot.
//   A granted slot emits the held word. An ungranted slot emits IDLE_CHAR
//   with the valid bit clear.
//
//   Build option:
//     LANE_SCHED_SKIP_EN  defined   -> work-conserving round-robin. The grant
//                                      goes to the first full lane at or
//                                      after ptr.
//                         undefined -> fixed TDM. Each slot belongs to lane
//                                      ptr, and ptr advances every slot.
//
//   Ports:
//     clk_4f      single clock, rising edge
//     reset       asynchronous, active-high
//     enable      scheduler run request
//     data0..3    lane inputs, bit 8 = valid, [7:0] = payload
//     ready       bit i = lane i can accept a word this cycle
//     out_data    registered slot output, bit 8 = valid, [7:0] = payload
//     out_lane    registered lane index of the slot that produced out_data
//     busy        registered, 1 while the FSM is not IDLE
//     sent_count  registered count of valid words emitted (wraps)
module lane_scheduler #(
    parameter logic [7:0] IDLE_CHAR = 8'hBC
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        enable,
    input  logic [8:0]  data0,
    input  logic [8:0]  data1,
    input  logic [8:0]  data2,
    input  logic [8:0]  data3,
    output logic [3:0]  ready,
    output logic [8:0]  out_data,
    output logic [1:0]  out_lane,
    output logic        busy,
    output logic [15:0] sent_count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [1:0]  ptr_nxt;
    logic [3:0]  full;
    logic [3:0]  full_nxt;
    logic [7:0]  hold [4];
    logic [8:0]  data_in [4];
    logic [3:0]  accept;
    logic        gnt_vld;
    logic [1:0]  gnt_lane;
    logic [3:0]  gnt_mask;

    assign data_in[0] = data0;
    assign data_in[1] = data1;
    assign data_in[2] = data2;
    assign data_in[3] = data3;

    // Only RUN admits new words; FLUSH drains, IDLE holds nothing.
    assign ready = (state == RUN) ? ~full : 4'b0000;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            accept[i] = data_in[i][8] & ready[i];
        end
    end

`ifdef LANE_SCHED_SKIP_EN
    // Scan from the farthest candidate back to ptr so the closest full
    // lane in circular order wins.
    always_comb begin
        logic [1:0] cand;
        gnt_vld  = 1'b0;
        gnt_lane = ptr;
        cand     = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (full[cand]) begin
                gnt_vld  = 1'b1;
                gnt_lane = cand;
            end
        end
        ptr_nxt = gnt_vld ? gnt_lane + 2'd1 : ptr;
    end
`else
    always_comb begin
        gnt_lane = ptr;
        gnt_vld  = full[ptr];
        ptr_nxt  = ptr + 2'd1;
    end
`endif

    assign gnt_mask = gnt_vld ? (4'b0001 << gnt_lane) : 4'b0000;
    // A granted lane is never ready, so the accept and grant masks are disjoint.
    assign full_nxt = (full & ~gnt_mask) | accept;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            // Any word still held, or landing at this edge, must be drained.
            RUN:     if (!enable) state_nxt = ((full != 4'b0000) || (accept != 4'b0000)) ? FLUSH : IDLE;
            FLUSH:   if (enable) state_nxt = RUN;
                     else if (full_nxt == 4'b0000) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            full       <= 4'b0000;
            out_data   <= {1'b0, IDLE_CHAR};
            out_lane   <= 2'd0;
            busy       <= 1'b0;
            sent_count <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                hold[i] <= 8'd0;
            end
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (state == IDLE) begin
                out_data <= {1'b0, IDLE_CHAR};
                out_lane <= 2'd0;
                ptr      <= 2'd0;
            end else begin
                ptr      <= ptr_nxt;
                full     <= full_nxt;
                out_lane <= gnt_lane;
                out_data <= gnt_vld ? {1'b1, hold[gnt_lane]} : {1'b0, IDLE_CHAR};
                if (gnt_vld) begin
                    sent_count <= sent_count + 16'd1;
                end
                for (int i = 0; i < 4; i++) begin
                    if (accept[i]) begin
                        hold[i] <= data_in[i][7:0];
                    end
                end
            end
        end
    end

endmodule

// File: doc/lane_scheduler.md
LANE_SCHEDULER -- requirements
Module: lane_scheduler

Interface
REQ-001 The block SHALL have parameter IDLE_CHAR, default 8'hBC, the payload emitted in slots with no valid word.
REQ-002 The block SHALL have port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: scheduler run request.
REQ-005 The block SHALL have ports data0, data1, data2, data3, input, 9 bits each: bit 8 = valid, bits [7:0] = payload.
REQ-006 The block SHALL have port ready, output, 4 bits: bit i = lane i can accept a word this cycle.
REQ-007 The block SHALL have port out_data, output, 9 bits, registered: bit 8 = valid, bits [7:0] = payload.
REQ-008 The block SHALL have port out_lane, output, 2 bits, registered: the lane whose slot produced out_data.
REQ-009 The block SHALL have port busy, output, 1 bit, registered: 1 when the state is not IDLE.
REQ-010 The block SHALL have port sent_count, output, 16 bits, registered: count of valid words emitted.

Function
REQ-011 Each lane SHALL have a one-word hold register and a full flag.
REQ-012 ready[i] SHALL equal ~full[i] in RUN and SHALL be 0 in IDLE and FLUSH.
REQ-013 Lane i SHALL accept data_i[7:0] and set full[i] at an edge where data_i[8]=1 and ready[i]=1; data_i[8]=0 is never captured.
REQ-014 The FSM SHALL have states IDLE, RUN and FLUSH.
REQ-015 FSM transitions SHALL be: IDLE->RUN on enable=1; RUN->IDLE on enable=0 with no full flag set; RUN->FLUSH on enable=0 with any full flag set; FLUSH->RUN on enable=1; FLUSH->IDLE once all full flags are clear, including a flag cleared by that cycle's grant.
REQ-016 In IDLE, each edge SHALL load out_data={1'b0,IDLE_CHAR} and out_lane=0, and SHALL clear the slot pointer ptr (2 bits) to 0.
REQ-017 In RUN and FLUSH, each edge SHALL issue exactly one slot per the Configuration section.
REQ-018 A granted lane g SHALL produce out_data={1'b1,hold[g]}, out_lane=g, and full[g] cleared at the same edge.
REQ-019 An ungranted slot SHALL produce out_data={1'b0,IDLE_CHAR}.
REQ-020 ptr SHALL wrap from 3 to 0.
REQ-021 Latency SHALL be one edge minimum: a word accepted at edge N appears on out_data no earlier than edge N+1.
REQ-022 Acceptance and grant SHALL never target the same lane at the same edge, since a full lane is not ready.
REQ-023 A lane cleared by a grant at edge N SHALL be able to accept at edge N+1.
REQ-024 sent_count SHALL increment by 1 on each edge emitting a valid word and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-025 Asserting reset SHALL immediately, without a clock edge, force: state=IDLE, ptr=0, all full flags=0, hold registers=0, out_data={1'b0,IDLE_CHAR}, out_lane=0, busy=0, sent_count=0, ready=4'b0000.
REQ-026 Reset asserted mid-operation SHALL discard all held words, with no partial emission after release.
REQ-027 After reset deasserts, the first state change SHALL occur on the first rising edge with enable=1.

Configuration
REQ-028 The block SHALL support macro LANE_SCHED_SKIP_EN.
REQ-029 With LANE_SCHED_SKIP_EN undefined (fixed TDM), the slot at each edge SHALL go to lane ptr, granted if full[ptr] else idle, and ptr SHALL increment every slot.
REQ-030 With LANE_SCHED_SKIP_EN defined (work-conserving round-robin), the grant SHALL go to the first full lane in circular order starting at ptr; on a grant to lane g, ptr SHALL become g+1 mod 4; with no full lane, the slot SHALL be idle and ptr SHALL stay unchanged.

Verification
REQ-031 Reset test: assert reset mid-RUN with lanes 1 and 3 full -> out_data=9'h0BC, busy=0, sent_count=0, and ready=0 immediately; no lane 1 or lane 3 word is emitted after release.
REQ-032 TDM test (macro undefined): enable=1, present lane0=8'h11 and lane2=8'h33 once each -> out_data sequence 1_11(lane0), 0_BC(lane1), 1_33(lane2), 0_BC(lane3); sent_count=2.
REQ-033 Skip test (macro defined): same stimulus as REQ-032 -> out_data 1_11(lane0) then 1_33(lane2) on consecutive edges; ptr=3 afterwards.
REQ-034 Flush test: all four lanes full, drop enable -> busy stays 1 and ready=0 until the four words are emitted, then IDLE with out_data=9'h0BC.
REQ-035 Backpressure test: hold data1[8]=1 continuously with payload incrementing on each accept -> lane 1 ready toggles per grant and no payload value is lost or duplicated.
REQ-036 Wrap test: preload sent_count to 16'hFFFE via 2 fewer than 65536 valid emissions, then send 3 words -> sent_count=16'h0001.
